timer_digit_chain: RTL

//   Parametrised multi-digit modulo counter chain for the timer subsystem; the successor to the single-digit decade counter.

---
 rtl/timer_digit_chain_if.sv | 26 ++
 rtl/timer_digit_chain.sv | 114 +++++++++++
 2 files changed

// File: rtl/timer_digit_chain_if.sv
// Bus bundle for the timer digit chain.
// The master drives the controls (clear, load, tick, direction).
// The slave returns the count, the ripple carry and the wrap pulse.
interface timer_digit_chain_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    logic                          clr;
    logic                          load;
    logic [NUM_DIGITS*DIGIT_W-1:0] load_val;
    logic                          in;
    logic                          dir;
    logic [NUM_DIGITS*DIGIT_W-1:0] cnt;
    logic                          tc;
    logic                          out_in;

    modport master (
        output clr, load, load_val, in, dir,
        input  cnt, tc, out_in
    );

    modport slave (
        input  clr, load, load_val, in, dir,
        output cnt, tc, out_in
    );
endinterface

// File: rtl/timer_digit_chain.sv
// Cascaded modulo digit counter.
// It counts up or down, and supports clear, a saturating parallel load,
// a combinational ripple carry (tc) and a registered one-cycle wrap pulse (out_in).
module timer_digit_chain #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int MOD_LO     = 10,
    parameter int MOD_TOP    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    timer_digit_chain_if.slave    bus
);
    typedef logic [DIGIT_W-1:0] digit_t;

    // Largest legal value of digit idx. The top digit has its own modulus.
    function automatic digit_t max_of(input int idx);
        if (idx == NUM_DIGITS - 1) begin
            max_of = digit_t'(MOD_TOP - 1);
        end else begin
            max_of = digit_t'(MOD_LO - 1);
        end
    endfunction

    // Clamp an out-of-range load field to the digit's maximum.
    function automatic digit_t sat(input int idx, input digit_t v);
        if (v > max_of(idx)) begin
            sat = max_of(idx);
        end else begin
            sat = v;
        end
    endfunction

    digit_t                      digit_q [NUM_DIGITS];
    logic   [NUM_DIGITS:0]       max_below;   // bit i: every digit below i is at its max
    logic   [NUM_DIGITS:0]       zero_below;  // bit i: every digit below i is zero
    logic                        terminal;
    logic                        out_in_q;
    logic                        out_in_d;
    logic   [NUM_DIGITS*DIGIT_W-1:0] cnt_flat;

    // Build the prefix carry/borrow chains that enable each digit to step.
    always_comb begin
        max_below     = '0;
        zero_below    = '0;
        max_below[0]  = 1'b1;
        zero_below[0] = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            max_below[i+1]  = max_below[i]  & (digit_q[i] == max_of(i));
            zero_below[i+1] = zero_below[i] & (digit_q[i] == '0);
        end
        terminal = bus.dir ? zero_below[NUM_DIGITS] : max_below[NUM_DIGITS];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            digit_t digit_d;
            logic   step;

            // Next digit value with priority clr > load > counting step.
            always_comb begin
                step    = bus.in & (bus.dir ? zero_below[gi] : max_below[gi]);
                digit_d = digit_q[gi];
                if (bus.clr) begin
                    digit_d = '0;
                end else if (bus.load) begin
                    digit_d = sat(gi, bus.load_val[gi*DIGIT_W +: DIGIT_W]);
                end else if (step) begin
                    if (bus.dir) begin
                        digit_d = (digit_q[gi] == '0) ? max_of(gi) : digit_q[gi] - 1'b1;
                    end else begin
                        digit_d = (digit_q[gi] == max_of(gi)) ? '0 : digit_q[gi] + 1'b1;
                    end
                end
            end

            // Digit register with synchronous reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    digit_q[gi] <= '0;
                end else begin
                    digit_q[gi] <= digit_d;
                end
            end
        end
    endgenerate

    // A wrap occurs only when a real counting step takes the chain past terminal.
    always_comb begin
        out_in_d = bus.in & terminal & ~bus.clr & ~bus.load;
    end

    // Wrap pulse register: high during the cycle that shows the wrapped value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_in_q <= 1'b0;
        end else begin
            out_in_q <= out_in_d;
        end
    end

    // Pack the digits onto the count output.
    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cnt_flat[i*DIGIT_W +: DIGIT_W] = digit_q[i];
        end
    end

    assign bus.cnt    = cnt_flat;
    assign bus.tc     = bus.in & terminal;
    assign bus.out_in = out_in_q;
endmodule
